// File: rtl/exu_mul_arb.sv
// exu_mul_arb: shares the pipelined integer multiplier between the core
// pipeline (requester 0, fixed priority) and an auxiliary tagged requester 1.
// A shadow pipeline tracks the owner of every in-flight operation; core
// results are returned directly, requester-1 results go through a small
// response FIFO whose space is reserved by credits at issue time.
module exu_mul_arb #(
   parameter int LAT          = 3,
   parameter int RESP_DEPTH   = 2,
   parameter int TAG_W        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             freeze,
   // core request (cannot be backpressured)
   input  logic             core_valid,
   input  logic [31:0]      core_a,
   input  logic [31:0]      core_b,
   input  logic             core_rs1_sign,
   input  logic             core_rs2_sign,
   input  logic             core_low,
   // requester-1 request
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic             req1_rs1_sign,
   input  logic             req1_rs2_sign,
   input  logic             req1_low,
   input  logic [TAG_W-1:0] req1_tag,
   // multiplier interface
   output logic             mul_valid,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   output logic             mul_rs1_sign,
   output logic             mul_rs2_sign,
   output logic             mul_low,
   input  logic [31:0]      mul_out,
   // core result
   output logic             core_res_valid,
   output logic [31:0]      core_res,
   // requester-1 response
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [31:0]      resp1_data,
   output logic [TAG_W-1:0] resp1_tag,
   // starvation relief
   output logic             core_stall_req
);

   localparam int FC_W  = $clog2(RESP_DEPTH + 1);
   localparam int IF_W  = $clog2(LAT + 1);
   localparam int SUM_W = ((FC_W > IF_W) ? FC_W : IF_W) + 1;
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   // shadow pipeline: one {valid, owner, tag} entry per multiplier stage
   logic             sh_v_q   [LAT];
   logic             sh_own_q [LAT];
   logic [TAG_W-1:0] sh_tag_q [LAT];

   // requester-1 bookkeeping
   logic [IF_W-1:0]  inflight1_q, inflight1_d;
   logic [FC_W-1:0]  fifo_cnt_q,  fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
   logic [ST_W-1:0]  starve_q,    starve_d;

   // response FIFO storage (no reset needed: guarded by fifo_cnt_q)
   logic [31:0]      fifo_data [RESP_DEPTH];
   logic [TAG_W-1:0] fifo_tag  [RESP_DEPTH];

   logic credit_ok;
   logic grant0, grant1;
   logic done;
   logic core_done;
   logic push1;
   logic pop1;

   // Credits: a requester-1 op may issue only if a FIFO slot is guaranteed
   // for it once every op already in flight or queued has landed.
   assign credit_ok = (SUM_W'(inflight1_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(RESP_DEPTH);

   // Fixed-priority arbitration; nothing is granted while frozen or in reset
   always_comb begin
      grant0 = rst_l & core_valid & ~freeze;
      grant1 = rst_l & req1_valid & ~core_valid & ~freeze & credit_ok;
   end

   assign req1_ready = grant1;
   assign mul_valid  = grant0 | grant1;

   // Operand/control mux toward the multiplier, zero when idle
   always_comb begin
      mul_a        = '0;
      mul_b        = '0;
      mul_rs1_sign = 1'b0;
      mul_rs2_sign = 1'b0;
      mul_low      = 1'b0;
      if (grant0) begin
         mul_a        = core_a;
         mul_b        = core_b;
         mul_rs1_sign = core_rs1_sign;
         mul_rs2_sign = core_rs2_sign;
         mul_low      = core_low;
      end else if (grant1) begin
         mul_a        = req1_a;
         mul_b        = req1_b;
         mul_rs1_sign = req1_rs1_sign;
         mul_rs2_sign = req1_rs2_sign;
         mul_low      = req1_low;
      end
   end

   // Completion happens only on an advancing cycle, so a frozen last stage
   // produces exactly one result once the freeze lifts.
   assign done      = sh_v_q[LAT-1] & ~freeze;
   assign core_done = done & ~sh_own_q[LAT-1];
   assign push1     = done &  sh_own_q[LAT-1];
   assign pop1      = resp1_valid & resp1_ready;

   assign core_res_valid = core_done;
   assign core_res       = core_done ? mul_out : '0;

   assign resp1_valid = (fifo_cnt_q != '0);
   assign resp1_data  = resp1_valid ? fifo_data[rd_ptr_q] : '0;
   assign resp1_tag   = resp1_valid ? fifo_tag[rd_ptr_q]  : '0;

   assign core_stall_req = (starve_q == ST_W'(STARVE_LIMIT)) & req1_valid;

   // Next-state for credit counter, FIFO pointers/count and starvation counter
   always_comb begin
      inflight1_d = inflight1_q;
      fifo_cnt_d  = fifo_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      starve_d    = starve_q;

      if (grant1 && !push1) begin
         inflight1_d = inflight1_q + IF_W'(1);
      end else if (!grant1 && push1) begin
         inflight1_d = inflight1_q - IF_W'(1);
      end

      if (push1 && !pop1) begin
         fifo_cnt_d = fifo_cnt_q + FC_W'(1);
      end else if (!push1 && pop1) begin
         fifo_cnt_d = fifo_cnt_q - FC_W'(1);
      end

      if (push1) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop1) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      // A pending request that loses arbitration ages; frozen cycles do not count
      if (!req1_valid || grant1) begin
         starve_d = '0;
      end else if (!freeze && (starve_q != ST_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + ST_W'(1);
      end
   end

   // State registers; reset discards every in-flight op and queued response
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < LAT; i++) begin
            sh_v_q[i]   <= 1'b0;
            sh_own_q[i] <= 1'b0;
            sh_tag_q[i] <= '0;
         end
         inflight1_q <= '0;
         fifo_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         starve_q    <= '0;
      end else begin
         if (!freeze) begin
            sh_v_q[0]   <= mul_valid;
            sh_own_q[0] <= grant1;
            sh_tag_q[0] <= req1_tag;
            for (int i = 1; i < LAT; i++) begin
               sh_v_q[i]   <= sh_v_q[i-1];
               sh_own_q[i] <= sh_own_q[i-1];
               sh_tag_q[i] <= sh_tag_q[i-1];
            end
         end
         inflight1_q <= inflight1_d;
         fifo_cnt_q  <= fifo_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         starve_q    <= starve_d;
      end
   end

   // Response FIFO write port
   always_ff @(posedge clk) begin
      if (push1) begin
         fifo_data[wr_ptr_q] <= mul_out;
         fifo_tag[wr_ptr_q]  <= sh_tag_q[LAT-1];
      end
   end

   // Credits must make a push into a full FIFO impossible
   always_ff @(posedge clk) begin
      if (rst_l && push1) begin
         assert (fifo_cnt_q != FC_W'(RESP_DEPTH));
      end
   end

endmodule

// File: tb/tb_exu_mul_arb.sv
// Self-checking bench for exu_mul_arb: a predictor derives grants, credits and
// starvation from the request history and queues the expected results; a
// monitor pops and compares whenever the DUT presents a result.
module tb_exu_mul_arb;

   localparam int LAT          = 3;
   localparam int RESP_DEPTH   = 2;
   localparam int TAG_W        = 4;
   localparam int STARVE_LIMIT = 8;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             freeze;
   logic             core_valid;
   logic [31:0]      core_a, core_b;
   logic             core_rs1_sign, core_rs2_sign, core_low;
   logic             req1_valid, req1_ready;
   logic [31:0]      req1_a, req1_b;
   logic             req1_rs1_sign, req1_rs2_sign, req1_low;
   logic [TAG_W-1:0] req1_tag;
   logic             mul_valid;
   logic [31:0]      mul_a, mul_b;
   logic             mul_rs1_sign, mul_rs2_sign, mul_low;
   logic [31:0]      mul_out;
   logic             core_res_valid;
   logic [31:0]      core_res;
   logic             resp1_valid, resp1_ready;
   logic [31:0]      resp1_data;
   logic [TAG_W-1:0] resp1_tag;
   logic             core_stall_req;

   exu_mul_arb #(
      .LAT(LAT), .RESP_DEPTH(RESP_DEPTH), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst_l(rst_l), .freeze(freeze),
      .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
      .core_rs1_sign(core_rs1_sign), .core_rs2_sign(core_rs2_sign), .core_low(core_low),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b),
      .req1_rs1_sign(req1_rs1_sign), .req1_rs2_sign(req1_rs2_sign), .req1_low(req1_low),
      .req1_tag(req1_tag),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_rs1_sign(mul_rs1_sign), .mul_rs2_sign(mul_rs2_sign), .mul_low(mul_low),
      .mul_out(mul_out),
      .core_res_valid(core_res_valid), .core_res(core_res),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_data(resp1_data), .resp1_tag(resp1_tag),
      .core_stall_req(core_stall_req)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; int due; } core_exp_t;
   typedef struct { logic [31:0] data; logic [TAG_W-1:0] tag; } r1_exp_t;

   core_exp_t core_q[$];
   r1_exp_t   r1_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int adv = 0;          // number of non-frozen clock edges so far
   int outstanding = 0;  // requester-1 ops accepted but not yet popped
   int starve = 0;       // consecutive blocked cycles of a pending req1
   logic hs = 1'b0;      // req1 handshake seen in the last cycle
   logic pg0, pg1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural multiply: extend each operand by its sign control, take low or high word
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s1, input logic s2, input logic low);
      logic [63:0] ea, eb, p;
      ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
      eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return low ? p[31:0] : p[63:32];
   endfunction

   // Stand-in multiplier: LAT stages, holds while frozen
   logic [31:0] mp_r [LAT];
   always @(posedge clk) begin
      if (!freeze) begin
         mp_r[0] <= mul_valid ? ref_mul(mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low)
                              : 32'hDEAD_BEEF;
         for (int i = 1; i < LAT; i++) mp_r[i] <= mp_r[i-1];
      end
   end
   assign mul_out = mp_r[LAT-1];

   always @(posedge clk) begin
      if (!freeze) adv <= adv + 1;
   end

   // Predictor: checks combinational grant outputs and queues expected results
   always @(posedge clk) begin
      #2;
      if (!rst_l) begin
         check("reset_outputs",
               {mul_valid, req1_ready, core_res_valid, resp1_valid, core_stall_req,
                |mul_a, |mul_b, |core_res, |resp1_data, |resp1_tag,
                mul_rs1_sign, mul_rs2_sign, mul_low}, 0);
         core_q.delete();
         r1_q.delete();
         outstanding = 0;
         starve = 0;
      end else begin
         pg0 = core_valid && !freeze;
         pg1 = req1_valid && !core_valid && !freeze && (outstanding < RESP_DEPTH);
         check("req1_ready", req1_ready, pg1);
         check("mul_valid", mul_valid, pg0 || pg1);
         check("core_stall_req", core_stall_req, (starve == STARVE_LIMIT) && req1_valid);
         if (pg0) begin
            check("mul_a_core", mul_a, core_a);
            core_q.push_back('{data: ref_mul(core_a, core_b, core_rs1_sign, core_rs2_sign, core_low),
                               due: adv + LAT});
         end
         if (pg1) begin
            check("mul_b_req1", mul_b, req1_b);
            r1_q.push_back('{data: ref_mul(req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low),
                             tag: req1_tag});
            outstanding++;
         end
         if (!req1_valid || pg1) starve = 0;
         else if (!freeze && starve < STARVE_LIMIT) starve++;
      end
   end

   // Monitor: pops expected results whenever the DUT presents one
   always @(negedge clk) begin
      core_exp_t ce;
      r1_exp_t   re;
      if (rst_l) begin
         if (core_res_valid) begin
            if (core_q.size() == 0) begin
               check("core_spurious", core_res_valid, 0);
            end else begin
               ce = core_q.pop_front();
               $display("[%0t] core result %08h (expected %08h)", $time, core_res, ce.data);
               check("core_res", core_res, ce.data);
               check("core_latency", adv, ce.due);
            end
         end else if (core_q.size() != 0 && core_q[0].due == adv && !freeze) begin
            check("core_missing", core_res_valid, 1);
            void'(core_q.pop_front());
         end
         if (resp1_valid) begin
            if (r1_q.size() == 0) begin
               check("resp1_spurious", resp1_valid, 0);
            end else if (resp1_ready) begin
               re = r1_q.pop_front();
               outstanding--;
               $display("[%0t] resp1 tag %0d data %08h (expected tag %0d data %08h)",
                        $time, resp1_tag, resp1_data, re.tag, re.data);
               check("resp1_data", resp1_data, re.data);
               check("resp1_tag", resp1_tag, re.tag);
            end
         end
      end
   end

   task automatic idle_inputs();
      freeze = 1'b0;
      core_valid = 1'b0; core_a = '0; core_b = '0;
      core_rs1_sign = 1'b0; core_rs2_sign = 1'b0; core_low = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      req1_rs1_sign = 1'b0; req1_rs2_sign = 1'b0; req1_low = 1'b0; req1_tag = '0;
   endtask

   task automatic set_req1(input logic [TAG_W-1:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic s1, input logic s2, input logic low);
      req1_valid = 1'b1; req1_tag = t; req1_a = a; req1_b = b;
      req1_rs1_sign = s1; req1_rs2_sign = s2; req1_low = low;
   endtask

   // One cycle: note the handshake, then move to just after the next edge
   task automatic tick();
      @(negedge clk);
      hs = req1_valid && req1_ready;
      @(posedge clk);
      #1;
   endtask

   // Hold the current req1 until accepted, within a cycle budget
   task automatic wait_accept(input string name, input int release_at);
      int waited;
      waited = 0;
      do begin
         tick();
         waited++;
         if (waited == release_at) resp1_ready = 1'b1;
      end while (!hs && waited < 40);
      if (!hs) check(name, 0, 1);
      req1_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      resp1_ready = 1'b0;
      rst_l = 1'b0;
      repeat (3) tick();
      rst_l = 1'b1;
      tick();

      // core only: 7*6 low word
      core_valid = 1'b1; core_a = 32'd7; core_b = 32'd6; core_low = 1'b1;
      tick();
      idle_inputs();
      repeat (5) tick();

      // requester 1 with credit: signed -1 * 2, high word
      resp1_ready = 1'b1;
      set_req1(4'd5, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 1'b0);
      tick();
      check("req1_same_cycle_accept", hs, 1);
      req1_valid = 1'b0;
      repeat (6) tick();

      // credit limit: tags 1,2 fit, tag 3 waits for a pop
      resp1_ready = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         set_req1(TAG_W'(t), $urandom, $urandom, 1'b0, 1'b1, t[0]);
         wait_accept("credit_accept_timeout", 8);
      end
      resp1_ready = 1'b1;
      repeat (8) tick();

      // contention: core wins for 10 cycles, stall request builds up
      set_req1(4'd9, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         core_valid = 1'b1; core_a = $urandom; core_b = $urandom; core_low = 1'b1;
         tick();
      end
      core_valid = 1'b0;
      wait_accept("contention_accept_timeout", 1);
      repeat (6) tick();

      // freeze: issue at cycle 0, freeze cycles 1-2
      core_valid = 1'b1; core_a = 32'd11; core_b = 32'd13; core_low = 1'b1;
      tick();
      idle_inputs();
      freeze = 1'b1;
      repeat (2) tick();
      freeze = 1'b0;
      repeat (6) tick();

      // reset mid-flight discards the requester-1 op
      set_req1(4'd7, 32'd100, 32'd200, 1'b0, 1'b0, 1'b1);
      tick();
      idle_inputs();
      rst_l = 1'b0;
      repeat (2) tick();
      rst_l = 1'b1;
      repeat (6) tick();
      set_req1(4'd3, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);
      tick();
      check("post_reset_accept", hs, 1);
      req1_valid = 1'b0;
      repeat (6) tick();

      // randomized traffic
      hs = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         freeze = ($urandom_range(0, 9) == 0);
         core_valid = ($urandom_range(0, 9) < 3);
         core_a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
         core_b = $urandom;
         core_rs1_sign = $urandom_range(0, 1);
         core_rs2_sign = $urandom_range(0, 1);
         core_low = $urandom_range(0, 1);
         if (!req1_valid || hs) begin
            if ($urandom_range(0, 1) == 1)
               set_req1(TAG_W'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
               req1_valid = 1'b0;
         end
         resp1_ready = ($urandom_range(0, 9) < 6);
         tick();
      end

      // drain and confirm every expected result appeared
      idle_inputs();
      resp1_ready = 1'b1;
      repeat (20) tick();
      check("drain_core_queue", core_q.size(), 0);
      check("drain_resp1_queue", r1_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/exu_mul_arb.md
Name: exu_mul_arb

Overview:
- Shares the 3-stage pipelined integer multiplier between two requesters:
  - the core pipeline (requester 0, the decode-issued mul packet);
  - an auxiliary requester 1 (accelerator / debug port) using a valid/ready handshake and a tag.
- Issues at most one operation per cycle into the multiplier.
- Tracks ownership of each in-flight operation in a shadow pipeline matched to multiplier latency.
- Returns core results directly; requester-1 results go through a credit-protected response FIFO.
- Sits in the EXU between decode/auxiliary sources and the multiplier.

Parameters:
- LAT, 3, multiplier latency in cycles (issue to result); shadow pipeline depth.
- RESP_DEPTH, 2, requester-1 response FIFO entries; also the requester-1 credit limit.
- TAG_W, 4, requester-1 tag width.
- STARVE_LIMIT, 8, consecutive blocked cycles of a pending requester-1 request before a core stall is requested.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- freeze  in  1  pipeline freeze; nothing advances while high.
- core_valid  in  1  core mul request; cannot be backpressured.
- core_a, core_b  in  32 each  core operands.
- core_rs1_sign, core_rs2_sign, core_low  in  1 each  core operation controls.
- req1_valid  in  1  requester-1 request valid.
- req1_ready  out  1  requester-1 request accepted this cycle.
- req1_a, req1_b  in  32 each  requester-1 operands.
- req1_rs1_sign, req1_rs2_sign, req1_low  in  1 each  requester-1 controls.
- req1_tag  in  TAG_W  requester-1 tag.
- mul_valid  out  1  issue strobe to multiplier.
- mul_a, mul_b  out  32 each  issued operands.
- mul_rs1_sign, mul_rs2_sign, mul_low  out  1 each  issued controls.
- mul_out  in  32  multiplier result, valid LAT cycles after issue.
- core_res_valid  out  1  core result strobe.
- core_res  out  32  core result.
- resp1_valid  out  1  requester-1 response valid.
- resp1_ready  in  1  requester-1 response accept.
- resp1_data  out  32  requester-1 response data.
- resp1_tag  out  TAG_W  requester-1 response tag.
- core_stall_req  out  1  asks decode to withhold core_valid.

Behaviour:
Reset:
- Async assert clears all shadow valids, the FIFO (empty), inflight1, and the starve counter.
- Every output is 0 during and after reset until a request arrives.
- Reset mid-operation discards in-flight ops; no stale response is produced.

Arbitration (combinational, same cycle):
- Core has fixed priority.
- credit_ok = inflight1 + fifo_cnt < RESP_DEPTH.
- grant0 = core_valid & ~freeze.
- grant1 = req1_valid & ~core_valid & ~freeze & credit_ok.
- req1_ready = grant1. A request is transferred only on req1_valid & req1_ready.
- mul_valid = grant0 | grant1. Operand/control mux selects the granted source; outputs are 0 when there is no grant.
- core_valid during freeze is a protocol error (decode is frozen too); ignore it.

Shadow pipeline:
- LAT stages of {valid, owner, tag}.
- Advances only when ~freeze. Stage 1 loads {mul_valid, grant1, req1_tag}. All stages hold during freeze.
- inflight1 counts owner=1 valid stages:
  - +1 on grant1;
  - -1 when the last stage holds owner=1 and ~freeze;
  - both in the same cycle: no change.

Completion (last stage valid & ~freeze):
- owner=0: core_res_valid=1 and core_res=mul_out for exactly one cycle. It is not repeated across freeze.
- owner=1: push {mul_out, tag} into the FIFO. Credit accounting guarantees the push never finds the FIFO full; overflow is an assertion failure.

Response FIFO:
- resp1_valid = fifo_cnt != 0. Head drives resp1_data / resp1_tag.
- Pop on resp1_valid & resp1_ready, independent of freeze.
- Push and pop in the same cycle: count unchanged, order preserved (FIFO order).
- Pointers wrap modulo RESP_DEPTH.

Starvation:
- Counter increments each cycle req1_valid & ~grant1 & ~freeze, saturating at STARVE_LIMIT.
- Clears on grant1, or when req1_valid is low.
- core_stall_req = (counter == STARVE_LIMIT) & req1_valid.
- If core_valid arrives anyway, core still wins.

Test Plan:
- Core-only: core_valid with a=7, b=6, low=1 at cycle 0 -> mul_valid at cycle 0; core_res_valid=1, core_res=42 at cycle 3 only; req1_ready=0 at cycle 0.
- Requester 1 with credit: req1 tag=5, a=0xFFFFFFFF, b=2, signed, low=0 -> accepted same cycle; resp1_valid at cycle 3, resp1_data=0xFFFFFFFF, tag=5.
- Credit limit: resp1_ready=0, req1_valid held with tags 1,2,3 -> only tags 1,2 accepted; req1_ready stays 0 until a pop, then tag 3 is accepted; responses return in order 1,2,3.
- Contention: core_valid and req1_valid high for 10 cycles -> req1_ready=0 throughout; core_stall_req rises after 8 blocked cycles; when core_valid drops, req1 is granted and core_stall_req falls the next cycle.
- Freeze: issue core op at cycle 0, freeze cycles 1-2 -> core_res_valid at cycle 5, single pulse; no issue during freeze.
- Reset mid-flight: req1 issued, rst_l low at cycle 1 -> resp1_valid never asserts; FIFO empty; req1_ready=1 on the first post-reset request.
